// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_pkg
// Description : Shared types and constants for the nibble-serial adder:
//               FSM state encoding, slice width, slice-count helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_pkg;

  // Width of one datapath slice (the 4-bit ripple adder)
  localparam int NIB_W = 4;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of 4-bit slices in a WIDTH-bit operand
  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

  // Slice index counter width, never less than one bit
  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_if
// Description : Operand-in / result-out valid-ready bundle for the
//               nibble-serial adder. The ovf signal exists only when
//               NIBBLE_SERIAL_ADDER_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  // Producer/consumer side (drives operands, accepts results)
  modport master (
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  // Adder side
  modport slave (
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface
`default_nettype wire

// File: rtl/nibble_add4.sv
`default_nettype none
// ============================================================================
// Module      : nibble_add4
// Description : 4-bit combinational ripple-carry adder slice. When
//               NIBBLE_SERIAL_ADDER_OVF_EN is defined it also exposes the
//               carry into bit 3 for signed-overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_add4
  import nibble_serial_adder_pkg::*;
(
  input  wire logic [NIB_W-1:0] a,
  input  wire logic [NIB_W-1:0] b,
  input  wire logic             ci,
  output      logic [NIB_W-1:0] s,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output      logic             c3,
`endif
  output      logic             co
);

  // w_c[i] is the carry into bit i; w_c[NIB_W] is the carry out
  logic [NIB_W:0] w_c;

  assign w_c[0] = ci;

  genvar gi;
  generate
    for (gi = 0; gi < NIB_W; gi++) begin : g_bit
      assign s[gi]     = a[gi] ^ b[gi] ^ w_c[gi];
      assign w_c[gi+1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign co = w_c[NIB_W];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign c3 = w_c[NIB_W-1];
`endif

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : WIDTH-bit adder computed one 4-bit slice per clock through a
//               single nibble_add4. Operands arrive on a valid/ready
//               handshake, the result leaves on another. Optional signed
//               overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input wire logic             clk,
  input wire logic             rst,
  nibble_serial_adder_if.slave bus
);

  localparam int NIB = nib_count(WIDTH);
  localparam int IW  = idx_width(NIB);

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
    end
  endgenerate

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_c;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [NIB_W-1:0] w_a_nib;
  logic [NIB_W-1:0] w_b_nib;
  logic [NIB_W-1:0] w_s;
  logic             w_co;
  logic             w_last;

  // Select the current slice of the captured operands
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int k = 0; k < NIB; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_nib = r_a[k*NIB_W +: NIB_W];
        w_b_nib = r_b[k*NIB_W +: NIB_W];
      end
    end
  end

  assign w_last = (r_idx == IW'(NIB - 1));

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic w_c3;
  logic r_ovf;

  nibble_add4 u_add4 (
    .a  (w_a_nib),
    .b  (w_b_nib),
    .ci (r_c),
    .s  (w_s),
    .c3 (w_c3),
    .co (w_co)
  );
`else
  nibble_add4 u_add4 (
    .a  (w_a_nib),
    .b  (w_b_nib),
    .ci (r_c),
    .s  (w_s),
    .co (w_co)
  );
`endif

  // Controller: capture, one slice per RUN cycle, hold result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_c         <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_c        <= bus.cin;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          // Only the slice addressed by r_idx is updated; others keep their value
          for (int k = 0; k < NIB; k++) begin
            if (r_idx == IW'(k)) begin
              r_sum[k*NIB_W +: NIB_W] <= w_s;
            end
          end
          r_c <= w_co;
          if (w_last) begin
            r_cout      <= w_co;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            r_ovf       <= w_c3 ^ w_co;
`endif
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign bus.ovf       = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder
// Description : Directed self-checking bench for nibble_serial_adder
//               (WIDTH=16). Overflow vectors run when
//               NIBBLE_SERIAL_ADDER_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  nibble_serial_adder_if #(.WIDTH(16)) bus ();

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, accept, check latency and result, then consume it
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    int edges;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    // Scramble the pins: the captured copies must be what gets added
    bus.a        = ~a;
    bus.b        = ~b;
    bus.cin      = ~cin;
    chk({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    edges = 0;
    while (edges < 20) begin
      tick();
      edges++;
      if (bus.out_valid) break;
    end
    chk({tag, "_latency"}, 32'(edges), 32'd4);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_out_valid_post"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready_post"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Directed sequence
  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;

    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    tick();

    run_op("basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    tick();
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    run_op("cin_only", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);
    tick();

    // Backpressure: 0x00F0 + 0x0F10 + 1 = 0x1001, result held for 5 cycles
    bus.a        = 16'h00F0;
    bus.b        = 16'h0F10;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) break;
    end
    chk("bp_valid_first", 32'(bus.out_valid), 32'd1);
    bus.a        = 16'hFFFF;
    bus.b        = 16'hFFFF;
    bus.cin      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("bp_sum", 32'(bus.sum), 32'h1001);
      chk("bp_cout", 32'(bus.cout), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_consumed", 32'(bus.out_valid), 32'd0);
    chk("bp_in_ready_next", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_no_capture_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_no_capture_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_sum_kept", 32'(bus.sum), 32'h1001);

    // Reset after two RUN edges
    bus.a        = 16'h5555;
    bus.b        = 16'h5555;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_sum", 32'(bus.sum), 32'd0);
    chk("mid_rst_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    tick();
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    tick();
    run_op("ovf_none", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
